// File: rtl/dmadd_pkg.sv
// Shared types for the matrix-add datapath controller: command opcodes,
// datapath instruction codes, FSM states and the queued command record.
package dmadd_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_INIT  = 2'b01,
    OP_LOAD  = 2'b10,
    OP_RUN   = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    INSN_MIN  = 2'b00,
    INSN_MAX  = 2'b01,
    INSN_MADD = 2'b10
  } insn_e;

  // The one unused instruction encoding; LOAD/RUN carrying it are rejected.
  localparam logic [1:0] INSN_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_INIT,
    ST_LOAD,
    ST_RUN,
    ST_CAPTURE,
    ST_RESULT
  } state_e;

  typedef struct packed {
    cmd_op_e    op;
    logic [3:0] index;
    logic [3:0] data;
    logic [1:0] insn;
    logic [7:0] len;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/dmadd_cmd_fifo.sv
// Synchronous command FIFO with combinational read of the head entry.
// A push is refused whenever the FIFO is full, even if a pop happens that cycle.
module dmadd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o     = (count_q == FULL_COUNT);
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dmadd_ctrl.sv
// Command sequencer for the matrix-add datapath: queues commands, drives the
// registered datapath strobes, and returns the result with its run length.
module dmadd_ctrl
  import dmadd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CLR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_index,
  input  logic [3:0]  cmd_data,
  input  logic [1:0]  cmd_insn,
  input  logic [7:0]  cmd_len,
  output logic        dp_rst_n,
  output logic        dp_load,
  output logic        dp_run,
  output logic [3:0]  dp_index,
  output logic [3:0]  dp_data,
  output logic [1:0]  dp_insn,
  input  logic [11:0] dp_out,
  input  logic        abort,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [11:0] res_data,
  output logic [7:0]  res_cycles,
  output logic        busy,
  output logic        err
);

  localparam logic [7:0] CLR_LAST = 8'(CLR_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       cyc_q, cyc_d;
  logic             err_q, err_d;
  logic             ready_q;
  logic             dp_rst_n_q, dp_rst_n_d, dp_load_q, dp_load_d, dp_run_q, dp_run_d;
  logic [3:0]       dp_index_q, dp_index_d, dp_data_q, dp_data_d;
  logic [1:0]       dp_insn_q, dp_insn_d;
  logic             res_valid_q, res_valid_d;
  logic [11:0]      res_data_q, res_data_d;
  logic [7:0]       res_cycles_q, res_cycles_d;
  logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [CMD_W-1:0] fifo_wdata, fifo_rdata;
  cmd_t             head;

  assign cmd_ready  = ready_q && !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = {cmd_op, cmd_index, cmd_data, cmd_insn, cmd_len};
  assign head       = cmd_t'(fifo_rdata);

  dmadd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cyc_d        = cyc_q;
    err_d        = err_q;
    fifo_pop     = 1'b0;
    dp_rst_n_d   = 1'b1;
    dp_load_d    = 1'b0;
    dp_run_d     = 1'b0;
    dp_index_d   = dp_index_q;
    dp_data_d    = dp_data_q;
    dp_insn_d    = dp_insn_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_cycles_d = res_cycles_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          unique case (head.op)
            OP_CLEAR: begin
              state_d    = ST_CLEAR;
              cnt_d      = CLR_LAST;
              dp_rst_n_d = 1'b0;
              err_d      = 1'b0;
            end
            OP_INIT: begin
              state_d   = ST_INIT;
              dp_insn_d = head.insn;
            end
            OP_LOAD: begin
              if (head.insn == INSN_INVALID) begin
                err_d = 1'b1;
              end else begin
                state_d    = ST_LOAD;
                dp_load_d  = 1'b1;
                dp_index_d = head.index;
                dp_data_d  = head.data;
                dp_insn_d  = head.insn;
              end
            end
            OP_RUN: begin
              if (head.insn == INSN_INVALID) begin
                err_d = 1'b1;
              end else if (head.len == 8'd0) begin
                state_d = ST_CAPTURE;
                cyc_d   = 8'd0;
              end else begin
                state_d   = ST_RUN;
                dp_run_d  = 1'b1;
                dp_insn_d = head.insn;
                cnt_d     = head.len - 8'd1;
                cyc_d     = 8'd1;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_CLEAR: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d      = cnt_q - 8'd1;
          dp_rst_n_d = 1'b0;
        end
      end
      ST_INIT, ST_LOAD: state_d = ST_IDLE;
      ST_RUN: begin
        // cnt_q holds the run cycles remaining after the current one.
        if (cnt_q == 8'd0 || abort) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d    = cnt_q - 8'd1;
          cyc_d    = cyc_q + 8'd1;
          dp_run_d = 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d      = ST_RESULT;
        res_valid_d  = 1'b1;
        res_data_d   = dp_out;
        res_cycles_d = cyc_q;
      end
      ST_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cyc_q        <= '0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
      dp_rst_n_q   <= 1'b0;
      dp_load_q    <= 1'b0;
      dp_run_q     <= 1'b0;
      dp_index_q   <= '0;
      dp_data_q    <= '0;
      dp_insn_q    <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      err_q        <= err_d;
      ready_q      <= 1'b1;
      dp_rst_n_q   <= dp_rst_n_d;
      dp_load_q    <= dp_load_d;
      dp_run_q     <= dp_run_d;
      dp_index_q   <= dp_index_d;
      dp_data_q    <= dp_data_d;
      dp_insn_q    <= dp_insn_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_cycles_q <= res_cycles_d;
    end
  end

  assign dp_rst_n   = dp_rst_n_q;
  assign dp_load    = dp_load_q;
  assign dp_run     = dp_run_q;
  assign dp_index   = dp_index_q;
  assign dp_data    = dp_data_q;
  assign dp_insn    = dp_insn_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_cycles = res_cycles_q;
  assign err        = err_q;
  assign busy       = !(state_q == ST_IDLE && fifo_empty);

endmodule

// File: doc/dmadd_ctrl.md
DMADD_CTRL -- requirements
Module: dmadd_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, command FIFO depth (power of 2, >=2).
REQ-002 The block SHALL have parameter CLR_CYCLES, default 2, cycles dp_rst_n is held low per CLEAR.
REQ-003 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports cmd_valid in 1, cmd_ready out 1, command handshake.
REQ-006 The block SHALL have port cmd_op  in  2  00 CLEAR, 01 INIT, 10 LOAD, 11 RUN.
REQ-007 The block SHALL have ports cmd_index in 4, cmd_data in 4, cmd_insn in 2, cmd_len in 8, command fields.
REQ-008 The block SHALL have datapath outputs dp_rst_n 1, dp_load 1, dp_run 1, dp_index 4, dp_data 4, dp_insn 2, all registered.
REQ-009 The block SHALL have input dp_out  12  datapath result.
REQ-010 The block SHALL have ports abort in 1, res_valid out 1, res_ready in 1, res_data out 12, res_cycles out 8, busy out 1, err out 1.

Function
REQ-011 cmd_ready SHALL equal FIFO-not-full; a push SHALL occur on cmd_valid && cmd_ready; a pop in the same cycle SHALL NOT make room for a push when full.
REQ-012 FSM states SHALL be IDLE, CLEAR, INIT, LOAD, RUN, CAPTURE, RESULT.
REQ-013 IDLE with FIFO non-empty SHALL pop one command and go to the state named by cmd_op; IDLE with FIFO empty SHALL stay.
REQ-014 LOAD or RUN with cmd_insn == 2'b11 SHALL be dropped, set sticky err, and return to IDLE the next cycle with no dp_* pulse.
REQ-015 CLEAR SHALL drive dp_rst_n=0 for exactly CLR_CYCLES cycles, then IDLE.
REQ-016 INIT SHALL drive dp_load=0, dp_run=0, dp_insn=cmd_insn for exactly one cycle, then IDLE.
REQ-017 LOAD SHALL drive dp_load=1, dp_index, dp_data, dp_insn from the command for exactly one cycle, then IDLE.
REQ-018 A popped command SHALL appear on dp_* the cycle after the pop (latency 1).
REQ-019 RUN SHALL hold dp_run=1 with dp_insn=cmd_insn for cmd_len cycles counted by an 8-bit down-counter, then go to CAPTURE; cmd_len=0 SHALL go directly to CAPTURE with zero run cycles.
REQ-020 abort asserted in RUN SHALL deassert dp_run the next cycle and go to CAPTURE; abort on the final run cycle SHALL behave identically to normal completion; abort outside RUN SHALL be ignored.
REQ-021 res_cycles SHALL equal the number of cycles dp_run was high for that command (0..255).
REQ-022 CAPTURE SHALL last one cycle (to absorb the datapath output register), then latch dp_out into res_data and enter RESULT.
REQ-023 RESULT SHALL hold res_valid=1 with res_data/res_cycles stable until res_ready; on res_valid && res_ready it SHALL clear res_valid and return to IDLE the same edge.
REQ-024 busy SHALL be 1 in every state except IDLE with FIFO empty.
REQ-025 err SHALL clear only on rst or a CLEAR command.
REQ-026 Outside their active states, dp_load, dp_run SHALL be 0 and dp_rst_n SHALL be 1.

Reset
REQ-027 rst SHALL asynchronously force IDLE, empty FIFO, dp_rst_n=0, dp_load=0, dp_run=0, dp_index/dp_data/dp_insn=0, res_valid=0, res_data=0, res_cycles=0, err=0, cmd_ready=0.
REQ-028 The first edge after rst deasserts SHALL set dp_rst_n=1 and cmd_ready=1.
REQ-029 rst mid-RUN or mid-RESULT SHALL discard the in-flight command and result without emitting res_valid.

Structure
REQ-030 A shared package SHALL hold cmd_op encodings, the FSM state enum, and datapath insn codes (MIN 00, MAX 01, MADD 10).
REQ-031 The command FIFO SHALL be a sub-module dmadd_cmd_fifo, parameterised by depth and width.

Verification
REQ-032 CLEAR then LOAD idx=5 data=3 insn=00 -> dp_rst_n low 2 cycles; dp_load high 1 cycle with dp_index=5, dp_data=3.
REQ-033 RUN len=10 insn=00, dp_out=12'h007 -> dp_run high 10 cycles; res_valid with res_data=12'h007, res_cycles=10.
REQ-034 RUN len=200, abort after 37 run cycles -> res_cycles=37, dp_run low next cycle.
REQ-035 Push 5 commands back-to-back with FIFO_DEPTH=4 while RESULT is stalled (res_ready=0) -> cmd_ready low after 4th; no command lost or reordered.
REQ-036 LOAD insn=11 -> err=1, no dp_load pulse; subsequent CLEAR -> err=0.
REQ-037 RUN len=0 -> res_valid with res_cycles=0; rst asserted during RUN len=50 -> no res_valid, all outputs at reset values.
